// File: rtl/quad_encoder_array.sv
// Multi-channel rotary quadrature decoder with synchroniser, glitch filter,
// wrap/saturating position registers, step strobe and sticky error flag.
module quad_encoder_array #(
    parameter int CHANNELS        = 3,
    parameter int VALUE_WIDTH     = 8,
    parameter int INCREMENT       = 1,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SATURATE        = 0,
    parameter int RESET_VALUE     = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [CHANNELS-1:0]             a,
    input  logic [CHANNELS-1:0]             b,
    input  logic [CHANNELS-1:0]             clear,
    output logic [CHANNELS*VALUE_WIDTH-1:0] values,
    output logic [CHANNELS-1:0]             step,
    output logic [CHANNELS-1:0]             dir,
    output logic [CHANNELS-1:0]             err
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [VALUE_WIDTH-1:0] INC = VALUE_WIDTH'(INCREMENT);
    localparam logic [VALUE_WIDTH-1:0] RST_V = VALUE_WIDTH'(RESET_VALUE);
    localparam logic [VALUE_WIDTH-1:0] MAX_V = '1;
    localparam logic [2:0] WARM_EDGES = 3'd4;

    logic [2:0] warm_cnt;
    logic       warm;

    assign warm = (warm_cnt != WARM_EDGES);

    // Settle window after reset so idle levels load without decoding.
    always_ff @(posedge clk) begin
        if (reset) begin
            warm_cnt <= '0;
        end else if (warm) begin
            warm_cnt <= warm_cnt + 3'd1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        // Index 0 is phase A, index 1 is phase B.
        logic [1:0]         s1;
        logic [1:0]         s2;
        logic [1:0]         filt;
        logic [1:0]         prev;
        logic [1:0][CW-1:0] cnt;
        logic [VALUE_WIDTH-1:0] val;
        logic               st;
        logic               d;
        logic               e;
        logic [3:0]         pat;
        logic               up;
        logic               dn;
        logic               bad;
        logic [VALUE_WIDTH:0] sum;
        logic [VALUE_WIDTH:0] diff;
        logic [VALUE_WIDTH-1:0] up_v;
        logic [VALUE_WIDTH-1:0] dn_v;

        always_ff @(posedge clk) begin
            if (reset) begin
                s1   <= '0;
                s2   <= '0;
                filt <= '0;
                prev <= '0;
                cnt  <= '0;
            end else begin
                s1   <= {b[g], a[g]};
                s2   <= s1;
                prev <= filt;
                for (int k = 0; k < 2; k++) begin
                    if (warm) begin
                        filt[k] <= s2[k];
                        cnt[k]  <= '0;
                    end else if (s2[k] == filt[k]) begin
                        cnt[k]  <= '0;
                    end else if (cnt[k] == DEB_LAST) begin
                        filt[k] <= s2[k];
                        cnt[k]  <= '0;
                    end else begin
                        cnt[k]  <= cnt[k] + 1'b1;
                    end
                end
            end
        end

        assign pat  = {filt[0], prev[0], filt[1], prev[1]};
        assign up   = (pat == 4'b1000) || (pat == 4'b0111);
        assign dn   = (pat == 4'b0010) || (pat == 4'b1101);
        assign bad  = (filt[0] ^ prev[0]) & (filt[1] ^ prev[1]);
        assign sum  = {1'b0, val} + {1'b0, INC};
        assign diff = {1'b0, val} - {1'b0, INC};
        assign up_v = (SATURATE != 0 && sum[VALUE_WIDTH])
                    ? MAX_V : sum[VALUE_WIDTH-1:0];
        assign dn_v = (SATURATE != 0 && diff[VALUE_WIDTH])
                    ? '0 : diff[VALUE_WIDTH-1:0];

        always_ff @(posedge clk) begin
            if (reset) begin
                val <= RST_V;
                st  <= 1'b0;
                d   <= 1'b0;
                e   <= 1'b0;
            end else if (clear[g]) begin
                val <= RST_V;
                st  <= 1'b0;
                e   <= 1'b0;
            end else begin
                st <= 1'b0;
                if (!warm) begin
                    unique case (1'b1)
                        up: begin
                            val <= up_v;
                            st  <= 1'b1;
                            d   <= 1'b1;
                        end
                        dn: begin
                            val <= dn_v;
                            st  <= 1'b1;
                            d   <= 1'b0;
                        end
                        bad: e <= 1'b1;
                        default: ;
                    endcase
                end
            end
        end

        assign values[g*VALUE_WIDTH +: VALUE_WIDTH] = val;
        assign step[g] = st;
        assign dir[g]  = d;
        assign err[g]  = e;
    end

endmodule

// File: tb/tb_quad_encoder_array.sv
// Scoreboard bench for quad_encoder_array: wrapping 3-channel instance
// plus a 1-channel saturating instance with a large step size.
module tb_quad_encoder_array;

    logic        clk;
    logic        reset;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [2:0]  clear;
    logic [23:0] values;
    logic [2:0]  step;
    logic [2:0]  dir;
    logic [2:0]  err;

    logic [0:0]  sa;
    logic [0:0]  sb;
    logic [0:0]  sclr;
    logic [7:0]  svalues;
    logic [0:0]  sstep;
    logic [0:0]  sdir;
    logic [0:0]  serr;

    quad_encoder_array dut (
        .clk    (clk),
        .reset  (reset),
        .a      (a),
        .b      (b),
        .clear  (clear),
        .values (values),
        .step   (step),
        .dir    (dir),
        .err    (err)
    );

    quad_encoder_array #(
        .CHANNELS    (1),
        .INCREMENT   (100),
        .SATURATE    (1),
        .RESET_VALUE (5)
    ) dut_s (
        .clk    (clk),
        .reset  (reset),
        .a      (sa),
        .b      (sb),
        .clear  (sclr),
        .values (svalues),
        .step   (sstep),
        .dir    (sdir),
        .err    (serr)
    );

    typedef struct {
        int ch;
        int val;
        int dir;
    } exp_t;

    exp_t q[$];
    exp_t qs[$];

    int checks = 0;
    int errors = 0;
    int stepcnt[4];
    bit ma[4];
    bit mb[4];
    int mv[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pin(input int idx, input bit na, input bit nb);
        if (idx < 3) begin
            a[idx] = na;
            b[idx] = nb;
        end else begin
            sa = na;
            sb = nb;
        end
    endtask

    // Reference decode: index 3 is the saturating instance.
    task automatic model(input int idx, input bit na, input bit nb,
                         input bit sup);
        bit [3:0] pat;
        int       inc;
        int       nv;
        int       nd;
        bit       hit;
        exp_t     e;
        pat = {na, ma[idx], nb, mb[idx]};
        inc = (idx == 3) ? 100 : 1;
        hit = 1'b0;
        nv  = mv[idx];
        nd  = 0;
        if (pat == 4'b1000 || pat == 4'b0111) begin
            nv  = mv[idx] + inc;
            nv  = (idx == 3) ? ((nv > 255) ? 255 : nv) : (nv % 256);
            nd  = 1;
            hit = 1'b1;
        end else if (pat == 4'b0010 || pat == 4'b1101) begin
            nv  = mv[idx] - inc;
            nv  = (idx == 3) ? ((nv < 0) ? 0 : nv) : ((nv + 256) % 256);
            nd  = 0;
            hit = 1'b1;
        end
        if (hit && !sup) begin
            mv[idx] = nv;
            e.ch  = (idx == 3) ? 0 : idx;
            e.val = nv;
            e.dir = nd;
            if (idx == 3) qs.push_back(e);
            else q.push_back(e);
        end
        ma[idx] = na;
        mb[idx] = nb;
    endtask

    task automatic move(input int idx, input bit na, input bit nb);
        pin(idx, na, nb);
        model(idx, na, nb, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            if (step[c]) begin
                stepcnt[c]++;
                if (q.size() == 0) begin
                    chk("unexp_step", c, -1);
                end else begin
                    e = q.pop_front();
                    chk("step_ch", c, e.ch);
                    chk("step_val", int'(values[c*8 +: 8]), e.val);
                    chk("step_dir", int'(dir[c]), e.dir);
                end
            end
        end
        if (sstep[0]) begin
            stepcnt[3]++;
            if (qs.size() == 0) begin
                chk("unexp_sstep", 3, -1);
            end else begin
                e = qs.pop_front();
                chk("sstep_val", int'(svalues), e.val);
                chk("sstep_dir", int'(sdir[0]), e.dir);
            end
        end
    end

    int sc;
    int lat;

    initial begin
        reset = 1'b1;
        a     = 3'b111;
        b     = 3'b111;
        clear = 3'b000;
        sa    = 1'b1;
        sb    = 1'b1;
        sclr  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ma[i] = 1'b1;
            mb[i] = 1'b1;
            mv[i] = (i == 3) ? 5 : 0;
            stepcnt[i] = 0;
        end

        run(20);
        chk("rst_values", int'(values), 0);
        chk("rst_step", int'(step), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_svalue", int'(svalues), 5);
        reset = 1'b0;
        run(20);
        chk("pwrup_values", int'(values), 0);
        chk("pwrup_steps", stepcnt[0] + stepcnt[1] + stepcnt[2], 0);

        // Ch0: 11->01 is one up step, then two full CW cycles.
        move(0, 0, 1); run(10);
        move(0, 0, 0); run(10);
        sc = stepcnt[0];
        for (int r = 0; r < 2; r++) begin
            move(0, 1, 0); run(10);
            move(0, 1, 1); run(10);
            move(0, 0, 1); run(10);
            move(0, 0, 0); run(10);
        end
        chk("cw_steps", stepcnt[0] - sc, 4);
        chk("cw_value", int'(values[7:0]), 5);
        chk("cw_dir", int'(dir[0]), 1);
        sc = stepcnt[0];
        for (int r = 0; r < 2; r++) begin
            move(0, 0, 1); run(10);
            move(0, 1, 1); run(10);
            move(0, 1, 0); run(10);
            move(0, 0, 0); run(10);
        end
        chk("ccw_steps", stepcnt[0] - sc, 4);
        chk("ccw_value", int'(values[7:0]), 1);
        chk("ccw_dir", int'(dir[0]), 0);

        // Ch1: 3-cycle glitch dropped, 4-cycle pulse counts.
        a[1] = 1'b0; run(3);
        a[1] = 1'b1; run(15);
        chk("glitch_value", int'(values[15:8]), 0);
        chk("glitch_steps", stepcnt[1], 0);
        move(1, 0, 1);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 4) move(1, 1, 1);
            if (step[1] && lat < 0) lat = n - 1;
        end
        chk("latency", lat, 6);
        chk("pulse_value", int'(values[15:8]), 1);

        // Ch0 wrap both ways.
        move(0, 0, 1); run(12);
        move(0, 1, 1); run(12);
        move(0, 1, 0); run(12);
        chk("wrap_down", int'(values[7:0]), 255);
        move(0, 1, 1); run(12);
        move(0, 0, 1); run(12);
        chk("wrap_up", int'(values[7:0]), 0);
        move(0, 0, 0); run(12);
        move(0, 0, 1); run(12);
        chk("wrap_down2", int'(values[7:0]), 255);

        // Saturating instance: 5 -> 105 -> 205 -> 255 -> 255.
        move(3, 0, 1); run(12);
        move(3, 0, 0); run(12);
        move(3, 1, 0); run(12);
        move(3, 1, 1); run(12);
        move(3, 0, 1); run(12);
        chk("sat_first", int'(svalues), 255);
        sc = stepcnt[3];
        move(3, 0, 0); run(12);
        move(3, 1, 0); run(12);
        chk("sat_clamp_step", stepcnt[3] - sc, 1);
        chk("sat_clamp_val", int'(svalues), 255);
        chk("sat_dir", int'(sdir[0]), 1);
        sclr = 1'b1; run(1);
        sclr = 1'b0; run(2);
        chk("sat_clear", int'(svalues), 5);
        mv[3] = 5;

        // Ch2: step, double change -> err, then clear beats a step.
        move(2, 0, 1); run(12);
        move(2, 1, 0); run(12);
        chk("err_flag", int'(err[2]), 1);
        chk("err_value", int'(values[23:16]), 1);
        move(2, 1, 1); run(12);
        sc = stepcnt[2];
        pin(2, 0, 1);
        model(2, 0, 1, 1'b1);
        mv[2] = 0;
        run(6);
        clear[2] = 1'b1; run(1);
        clear[2] = 1'b0; run(12);
        chk("clr_value", int'(values[23:16]), 0);
        chk("clr_err", int'(err[2]), 0);
        chk("clr_nostep", stepcnt[2] - sc, 0);

        // All channels step on the same edge.
        move(0, 0, 0);
        move(2, 0, 0);
        run(12);
        move(0, 1, 0);
        move(1, 0, 1);
        move(2, 0, 1);
        run(12);
        chk("multi_v0", int'(values[7:0]), 0);
        chk("multi_v1", int'(values[15:8]), 2);
        chk("multi_v2", int'(values[23:16]), 255);

        // Reset while steps are mid-debounce.
        move(0, 0, 0);
        move(1, 0, 0);
        move(2, 0, 0);
        run(12);
        pin(0, 1, 0);
        pin(1, 1, 0);
        pin(2, 1, 0);
        run(3);
        reset = 1'b1; run(3);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ma[i] = 1'b1;
            mb[i] = 1'b0;
            mv[i] = 0;
        end
        mv[3] = 5;
        sc = stepcnt[0] + stepcnt[1] + stepcnt[2];
        run(30);
        chk("rst2_values", int'(values), 0);
        chk("rst2_err", int'(err), 0);
        chk("rst2_svalue", int'(svalues), 5);
        chk("rst2_nostep", stepcnt[0] + stepcnt[1] + stepcnt[2] - sc, 0);
        chk("q_empty", q.size(), 0);
        chk("qs_empty", qs.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
